// File: rtl/trigger_ctrl.sv
// Command sequencer: decodes opcode/payload into trigger stage writes, arm and post-trigger delay count.
// Latency: every strobe/pulse appears one cycle after command acceptance; done_o one cycle after last counted stb_i.
// Backpressure: none, cmd_rdy_o is held high; commands that are illegal for the current state are dropped with ign_o.
module trigger_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DLY_SHIFT = 2
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [7:0]       opc_i,
  input  logic [31:0]      data_i,
  input  logic             cmd_vld_i,
  output logic             cmd_rdy_o,
  input  logic             run_i,
  input  logic             stb_i,
  output logic [31:0]      cmd_o,
  output logic             set_mask_o,
  output logic             set_val_o,
  output logic             set_cfg_o,
  output logic [1:0]       stg_o,
  output logic             arm_o,
  output logic             exec_o,
  output logic             soft_rst_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ign_o
);

  // One extra bit so (all-ones + 1) << DLY_SHIFT is represented without wrapping.
  localparam int CW = CNT_W + DLY_SHIFT + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DELAY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic [31:0]      cmd_q, cmd_d;
  logic [1:0]       stg_q, stg_d;
  logic             set_mask_q, set_mask_d;
  logic             set_val_q, set_val_d;
  logic             set_cfg_q, set_cfg_d;
  logic             arm_q, arm_d;
  logic             soft_rst_q, soft_rst_d;
  logic             done_q, done_d;
  logic             ign_q, ign_d;
  logic [CW-1:0]    cnt_load;

  // Next-state, counter and command decode; soft reset (0x00) is evaluated last so it overrides run/strobe effects.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    rd_d       = rd_q;
    cmd_d      = cmd_q;
    stg_d      = stg_q;
    set_mask_d = 1'b0;
    set_val_d  = 1'b0;
    set_cfg_d  = 1'b0;
    arm_d      = 1'b0;
    soft_rst_d = 1'b0;
    done_d     = 1'b0;
    ign_d      = 1'b0;
    cnt_load   = (CW'(dly_q) + CW'(1)) << DLY_SHIFT;

    case (state_q)
      S_ARMED: begin
        // A strobe coinciding with the trigger is not counted: the counter is only loaded here.
        if (run_i) begin
          state_d = S_DELAY;
          cnt_d   = cnt_load;
        end
      end
      S_DELAY: begin
        if (stb_i) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (cmd_vld_i) begin
      if (opc_i == 8'h00) begin
        soft_rst_d = 1'b1;
        state_d    = S_IDLE;
        cnt_d      = '0;
        done_d     = 1'b0;
      end else if (state_q != S_IDLE) begin
        ign_d = 1'b1;
      end else if (opc_i[7:4] == 4'hC) begin
        if (opc_i[1:0] == 2'b11) begin
          ign_d = 1'b1;
        end else begin
          stg_d      = opc_i[3:2];
          cmd_d      = data_i;
          set_mask_d = (opc_i[1:0] == 2'b00);
          set_val_d  = (opc_i[1:0] == 2'b01);
          set_cfg_d  = (opc_i[1:0] == 2'b10);
        end
      end else if (opc_i == 8'h81) begin
        rd_d  = data_i[16 +: CNT_W];
        dly_d = data_i[0 +: CNT_W];
      end else if (opc_i == 8'h01) begin
        arm_d   = 1'b1;
        state_d = S_ARMED;
      end else begin
        ign_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dly_q      <= '0;
      rd_q       <= '0;
      cmd_q      <= '0;
      stg_q      <= '0;
      set_mask_q <= 1'b0;
      set_val_q  <= 1'b0;
      set_cfg_q  <= 1'b0;
      arm_q      <= 1'b0;
      soft_rst_q <= 1'b0;
      done_q     <= 1'b0;
      ign_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      rd_q       <= rd_d;
      cmd_q      <= cmd_d;
      stg_q      <= stg_d;
      set_mask_q <= set_mask_d;
      set_val_q  <= set_val_d;
      set_cfg_q  <= set_cfg_d;
      arm_q      <= arm_d;
      soft_rst_q <= soft_rst_d;
      done_q     <= done_d;
      ign_q      <= ign_d;
    end
  end

  assign cmd_rdy_o  = 1'b1;
  assign cmd_o      = cmd_q;
  assign stg_o      = stg_q;
  assign set_mask_o = set_mask_q;
  assign set_val_o  = set_val_q;
  assign set_cfg_o  = set_cfg_q;
  assign arm_o      = arm_q;
  assign soft_rst_o = soft_rst_q;
  assign done_o     = done_q;
  assign ign_o      = ign_q;
  assign rd_cnt_o   = rd_q;
  assign exec_o     = (state_q != S_IDLE);
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_trigger_ctrl.sv
// Bench for trigger_ctrl: directed command/run/strobe sequences.
// Expected pulses are queued by the stimulus and checked by a monitor on the falling edge.
// Held outputs (stg, cmd, rd_cnt, exec/busy) are checked alongside every pulse.
module tb_trigger_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic [7:0]  opc_i;
  logic [31:0] data_i;
  logic        cmd_vld_i;
  logic        cmd_rdy_o;
  logic        run_i;
  logic        stb_i;
  logic [31:0] cmd_o;
  logic        set_mask_o, set_val_o, set_cfg_o;
  logic [1:0]  stg_o;
  logic        arm_o, exec_o, soft_rst_o;
  logic [15:0] rd_cnt_o;
  logic        busy_o, done_o, ign_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse vector order: {set_mask, set_val, set_cfg, arm, soft_rst, done, ign}
  localparam logic [6:0] P_MASK = 7'b1000000;
  localparam logic [6:0] P_VAL  = 7'b0100000;
  localparam logic [6:0] P_CFG  = 7'b0010000;
  localparam logic [6:0] P_ARM  = 7'b0001000;
  localparam logic [6:0] P_SRST = 7'b0000100;
  localparam logic [6:0] P_DONE = 7'b0000010;
  localparam logic [6:0] P_IGN  = 7'b0000001;

  typedef struct packed {
    logic [6:0]  p;
    logic [1:0]  stg;
    logic [31:0] cmd;
    logic [15:0] rd;
    logic        ex;
  } exp_t;

  exp_t sb_q[$];

  trigger_ctrl #(.CNT_W(16), .DLY_SHIFT(2)) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .opc_i      (opc_i),
    .data_i     (data_i),
    .cmd_vld_i  (cmd_vld_i),
    .cmd_rdy_o  (cmd_rdy_o),
    .run_i      (run_i),
    .stb_i      (stb_i),
    .cmd_o      (cmd_o),
    .set_mask_o (set_mask_o),
    .set_val_o  (set_val_o),
    .set_cfg_o  (set_cfg_o),
    .stg_o      (stg_o),
    .arm_o      (arm_o),
    .exec_o     (exec_o),
    .soft_rst_o (soft_rst_o),
    .rd_cnt_o   (rd_cnt_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ign_o      (ign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] p, input logic [1:0] stg, input logic [31:0] cmd,
                              input logic [15:0] rd, input logic ex);
    exp_t e;
    e.p = p; e.stg = stg; e.cmd = cmd; e.rd = rd; e.ex = ex;
    return e;
  endfunction

  // Monitor: any pulse on the falling edge must match the oldest queued expectation.
  initial begin
    logic [6:0] pv;
    exp_t e;
    forever begin
      @(negedge clk_i);
      pv = {set_mask_o, set_val_o, set_cfg_o, arm_o, soft_rst_o, done_o, ign_o};
      if (pv != 7'b0) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: got pulses 0x%0h expected none at %0t", pv, $time);
        end else begin
          e = sb_q.pop_front();
          chk("pulses", 32'(pv), 32'(e.p));
          chk("stg_o", 32'(stg_o), 32'(e.stg));
          chk("cmd_o", cmd_o, e.cmd);
          chk("rd_cnt_o", 32'(rd_cnt_o), 32'(e.rd));
          chk("exec_o", 32'(exec_o), 32'(e.ex));
          chk("busy_o", 32'(busy_o), 32'(e.ex));
        end
      end
    end
  end

  // One clock of stimulus, starting just after a rising edge.
  task automatic cyc(input logic vld, input logic [7:0] opc, input logic [31:0] d,
                     input logic run, input logic stb);
    cmd_vld_i = vld; opc_i = opc; data_i = d; run_i = run; stb_i = stb;
    @(posedge clk_i);
    #1;
    cmd_vld_i = 1'b0; opc_i = 8'h00; data_i = 32'h0; run_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] opc, input logic [31:0] d);
    cyc(1'b1, opc, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic strobe();
    cyc(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    idle(1);
  endtask

  initial begin
    rst_in = 1'b0; cmd_vld_i = 1'b0; opc_i = 8'h00; data_i = 32'h0; run_i = 1'b0; stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    // Reset state
    chk("rst_cmd_rdy", 32'(cmd_rdy_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_exec", 32'(exec_o), 32'd0);
    chk("rst_cmd_o", cmd_o, 32'h0);
    chk("rst_rd_cnt", 32'(rd_cnt_o), 32'h0);
    chk("rst_stg", 32'(stg_o), 32'h0);
    chk("rst_pulses", 32'({set_mask_o, set_val_o, set_cfg_o, arm_o, soft_rst_o, done_o, ign_o}), 32'h0);
    rst_in = 1'b1;
    idle(1);

    // Stage configuration
    sb_q.push_back(mk(P_IGN, 2'd0, 32'h0, 16'h0, 1'b0));
    send(8'hC3, 32'h0);
    sb_q.push_back(mk(P_MASK, 2'd1, 32'h0000_00FF, 16'h0, 1'b0));
    send(8'hC4, 32'h0000_00FF);
    sb_q.push_back(mk(P_VAL, 2'd1, 32'h0000_A5A5, 16'h0, 1'b0));
    send(8'hC5, 32'h0000_A5A5);
    sb_q.push_back(mk(P_CFG, 2'd2, 32'h0000_1234, 16'h0, 1'b0));
    send(8'hCA, 32'h0000_1234);
    send(8'h81, 32'h0010_0001);
    chk("rd_cnt_latched", 32'(rd_cnt_o), 32'h10);
    chk("cmd_rdy_idle", 32'(cmd_rdy_o), 32'd1);

    // run_i outside ARMED has no effect
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
    chk("run_in_idle_exec", 32'(exec_o), 32'd0);

    // Capture: dly=1 -> 8 strobes; the strobe with run_i is not counted
    sb_q.push_back(mk(P_ARM, 2'd2, 32'h0000_1234, 16'h10, 1'b1));
    send(8'h01, 32'h0);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
    chk("delay_busy", 32'(busy_o), 32'd1);
    chk("cmd_rdy_delay", 32'(cmd_rdy_o), 32'd1);
    for (int i = 0; i < 7; i++) strobe();
    sb_q.push_back(mk(P_DONE, 2'd2, 32'h0000_1234, 16'h10, 1'b0));
    strobe();
    idle(1);

    // Abort in DELAY after 3 strobes
    sb_q.push_back(mk(P_ARM, 2'd2, 32'h0000_1234, 16'h10, 1'b1));
    send(8'h01, 32'h0);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe();
    sb_q.push_back(mk(P_SRST, 2'd2, 32'h0000_1234, 16'h10, 1'b0));
    send(8'h00, 32'h0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 6; i++) strobe();
    chk("abort_rd_kept", 32'(rd_cnt_o), 32'h10);

    // Drops: stage write while ARMED, unknown opcode in IDLE
    sb_q.push_back(mk(P_ARM, 2'd2, 32'h0000_1234, 16'h10, 1'b1));
    send(8'h01, 32'h0);
    sb_q.push_back(mk(P_IGN, 2'd2, 32'h0000_1234, 16'h10, 1'b1));
    send(8'hC0, 32'h0000_ABCD);
    sb_q.push_back(mk(P_SRST, 2'd2, 32'h0000_1234, 16'h10, 1'b0));
    send(8'h00, 32'h0);
    sb_q.push_back(mk(P_IGN, 2'd2, 32'h0000_1234, 16'h10, 1'b0));
    send(8'h55, 32'h0);

    // dly=0 -> 4 strobes
    send(8'h81, 32'h0020_0000);
    chk("rd_cnt_relatch", 32'(rd_cnt_o), 32'h20);
    sb_q.push_back(mk(P_ARM, 2'd2, 32'h0000_1234, 16'h20, 1'b1));
    send(8'h01, 32'h0);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe();
    sb_q.push_back(mk(P_DONE, 2'd2, 32'h0000_1234, 16'h20, 1'b0));
    strobe();
    idle(1);

    // Soft reset coinciding with the last strobe wins: no done_o
    sb_q.push_back(mk(P_ARM, 2'd2, 32'h0000_1234, 16'h20, 1'b1));
    send(8'h01, 32'h0);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe();
    sb_q.push_back(mk(P_SRST, 2'd2, 32'h0000_1234, 16'h20, 1'b0));
    cyc(1'b1, 8'h00, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) strobe();

    // rst_in low during DELAY clears everything
    sb_q.push_back(mk(P_ARM, 2'd2, 32'h0000_1234, 16'h20, 1'b1));
    send(8'h01, 32'h0);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    strobe();
    rst_in = 1'b0;
    @(posedge clk_i);
    #1;
    rst_in = 1'b1;
    chk("hrst_exec", 32'(exec_o), 32'd0);
    chk("hrst_rd_cnt", 32'(rd_cnt_o), 32'h0);
    chk("hrst_cmd_o", cmd_o, 32'h0);
    chk("hrst_stg", 32'(stg_o), 32'h0);
    for (int i = 0; i < 4; i++) strobe();
    idle(2);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
